// File: rtl/gpio_bank.sv
// gpio_bank: a bank of embedded I/O channels between the SoC pads and the FPGA fabric.
// The output path is registered. The input path runs through a synchroniser, a per-channel
// debounce and a gate on config_done/isolation. Rising and falling edges of the debounced
// level can raise sticky, write-1-to-clear interrupt flags.
module gpio_bank #(
  parameter int NUM_IO       = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int DB_W         = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              config_done,
  input  logic              io_isol_n,
  input  logic [NUM_IO-1:0] soc_in,
  output logic [NUM_IO-1:0] soc_out,
  output logic [NUM_IO-1:0] soc_dir,
  input  logic [NUM_IO-1:0] fpga_out,
  input  logic [NUM_IO-1:0] fpga_dir,
  output logic [NUM_IO-1:0] fpga_in,
  input  logic [NUM_IO-1:0] rise_en,
  input  logic [NUM_IO-1:0] fall_en,
  input  logic [NUM_IO-1:0] irq_clr,
  output logic [NUM_IO-1:0] irq_status,
  output logic              irq
);

  logic              active;
  logic [NUM_IO-1:0] sync_p [SYNC_STAGES];
  logic [NUM_IO-1:0] sync_q;
  logic [NUM_IO-1:0] stable;
  logic [NUM_IO-1:0] prev;
  logic [NUM_IO-1:0] rise;
  logic [NUM_IO-1:0] fall;
  logic [NUM_IO-1:0] irq_set;

  // Both directions are live only once the fabric is configured and the ring is not isolated.
  assign active = config_done & io_isol_n;

  // Output path: the pad follows the fabric one cycle later. When inactive, the pad is parked as an input driving 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      soc_out <= '0;
      soc_dir <= '1;
    end else if (active) begin
      soc_out <= fpga_out;
      soc_dir <= fpga_dir;
    end else begin
      soc_out <= '0;
      soc_dir <= '1;
    end
  end

  // Input synchroniser chain. It runs whether or not the bank is active, so the level is already settled when the bank is enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= soc_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign sync_q = sync_p[SYNC_STAGES-1];

  // ---- debounce stage: sync_q -> stable ----
  if (DEBOUNCE_CYC == 0) begin : g_bypass
    // Debounce bypassed: the stable register only adds one cycle.
    always_ff @(posedge clk) begin
      if (reset) stable <= '0;
      else       stable <= sync_q;
    end
  end else begin : g_debounce
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYC - 1);
    logic [DB_W-1:0] cnt [NUM_IO];

    // A new level is accepted only after it differs from stable for DEBOUNCE_CYC consecutive edges.
    always_ff @(posedge clk) begin
      if (reset) begin
        stable <= '0;
        for (int i = 0; i < NUM_IO; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < NUM_IO; i++) begin
          if (sync_q[i] == stable[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync_q[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // ---- edge detect / interrupt stage: stable -> irq_status ----
  assign rise    = stable & ~prev;
  assign fall    = ~stable & prev;
  assign irq_set = {NUM_IO{active}} & ((rise & rise_en) | (fall & fall_en));

  // Sticky edge flags. A clear and a new edge on the same cycle leave the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      irq_status <= '0;
    end else begin
      prev       <= stable;
      irq_status <= (irq_status & ~irq_clr) | irq_set;
    end
  end

  assign fpga_in = active ? stable : '0;
  assign irq     = |irq_status;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: scenario tasks for gpio_bank (8 channels, 2 sync stages, 4-cycle debounce).
module tb_gpio_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       config_done;
  logic       io_isol_n;
  logic [7:0] soc_in;
  logic [7:0] soc_out;
  logic [7:0] soc_dir;
  logic [7:0] fpga_out;
  logic [7:0] fpga_dir;
  logic [7:0] fpga_in;
  logic [7:0] rise_en;
  logic [7:0] fall_en;
  logic [7:0] irq_clr;
  logic [7:0] irq_status;
  logic       irq;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  logic [7:0] e;

  gpio_bank #(
    .NUM_IO(8), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .DB_W(3)
  ) dut (
    .clk(clk), .reset(reset), .config_done(config_done), .io_isol_n(io_isol_n),
    .soc_in(soc_in), .soc_out(soc_out), .soc_dir(soc_dir),
    .fpga_out(fpga_out), .fpga_dir(fpga_dir), .fpga_in(fpga_in),
    .rise_en(rise_en), .fall_en(fall_en), .irq_clr(irq_clr),
    .irq_status(irq_status), .irq(irq)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; config_done = 1'b1; io_isol_n = 1'b1;
    fpga_out = 8'hFF; fpga_dir = 8'h00; soc_in = 8'h00;
    rise_en = 8'h00; fall_en = 8'h00; irq_clr = 8'h00;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    step(2);
    e = exp_q.pop_front(); vectors++;
    if (soc_out !== e) begin miscompares++; $display("FAIL reset_soc_out got=%h exp=%h", soc_out, e); end
    e = exp_q.pop_front(); vectors++;
    if (soc_dir !== e) begin miscompares++; $display("FAIL reset_soc_dir got=%h exp=%h", soc_dir, e); end
    e = exp_q.pop_front(); vectors++;
    if (fpga_in !== e) begin miscompares++; $display("FAIL reset_fpga_in got=%h exp=%h", fpga_in, e); end
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL reset_irq_status got=%h exp=%h", irq_status, e); end
    e = exp_q.pop_front(); vectors++;
    if ({7'd0, irq} !== e) begin miscompares++; $display("FAIL reset_irq got=%b exp=%b", irq, e[0]); end
    reset = 1'b0;
  endtask

  task automatic test_output_path();
    fpga_out = 8'hA5; fpga_dir = 8'h0F;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h0F);
    step(1);
    e = exp_q.pop_front(); vectors++;
    if (soc_out !== e) begin miscompares++; $display("FAIL out_soc_out got=%h exp=%h", soc_out, e); end
    e = exp_q.pop_front(); vectors++;
    if (soc_dir !== e) begin miscompares++; $display("FAIL out_soc_dir got=%h exp=%h", soc_dir, e); end
    io_isol_n = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    step(1);
    e = exp_q.pop_front(); vectors++;
    if (soc_out !== e) begin miscompares++; $display("FAIL isol_soc_out got=%h exp=%h", soc_out, e); end
    e = exp_q.pop_front(); vectors++;
    if (soc_dir !== e) begin miscompares++; $display("FAIL isol_soc_dir got=%h exp=%h", soc_dir, e); end
    e = exp_q.pop_front(); vectors++;
    if (fpga_in !== e) begin miscompares++; $display("FAIL isol_fpga_in got=%h exp=%h", fpga_in, e); end
    io_isol_n = 1'b1;
    step(1);
  endtask

  task automatic test_debounce();
    soc_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) exp_q.push_back((k == 6) ? 8'h01 : 8'h00);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      e = exp_q.pop_front(); vectors++;
      if (fpga_in !== e) begin miscompares++; $display("FAIL db_latency edge=%0d got=%h exp=%h", k, fpga_in, e); end
    end
    // A 3-cycle pulse on channel 1 is too short to be accepted.
    soc_in[1] = 1'b1;
    for (int k = 0; k < 13; k++) exp_q.push_back(8'h00);
    for (int k = 0; k < 13; k++) begin
      if (k == 3) soc_in[1] = 1'b0;
      step(1);
      e = exp_q.pop_front(); vectors++;
      if ((fpga_in & 8'h02) !== e) begin miscompares++; $display("FAIL db_glitch step=%0d got=%h exp=%h", k, fpga_in, e); end
    end
    exp_q.push_back(8'h00);
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL db_glitch_irq got=%h exp=%h", irq_status, e); end
  endtask

  task automatic test_irq_rise_clear();
    soc_in[0] = 1'b0;
    step(8);
    rise_en = 8'h01;
    soc_in[0] = 1'b1;
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    step(6);
    e = exp_q.pop_front(); vectors++;
    if ((fpga_in & 8'h01) !== e) begin miscompares++; $display("FAIL rise_fpga_in got=%h exp=%h", fpga_in, e); end
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL rise_status_early got=%h exp=%h", irq_status, e); end
    exp_q.push_back(8'h01); exp_q.push_back(8'h01);
    step(1);
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL rise_status got=%h exp=%h", irq_status, e); end
    e = exp_q.pop_front(); vectors++;
    if ({7'd0, irq} !== e) begin miscompares++; $display("FAIL rise_irq got=%b exp=%b", irq, e[0]); end
    irq_clr = 8'h01;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    step(1);
    irq_clr = 8'h00;
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL clr_status got=%h exp=%h", irq_status, e); end
    e = exp_q.pop_front(); vectors++;
    if ({7'd0, irq} !== e) begin miscompares++; $display("FAIL clr_irq got=%b exp=%b", irq, e[0]); end
  endtask

  task automatic test_set_wins();
    rise_en = 8'h00; fall_en = 8'h04;
    soc_in[2] = 1'b1;
    step(8);
    soc_in[2] = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    step(6);
    e = exp_q.pop_front(); vectors++;
    if ((fpga_in & 8'h04) !== e) begin miscompares++; $display("FAIL fall_fpga_in got=%h exp=%h", fpga_in, e); end
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL fall_status_early got=%h exp=%h", irq_status, e); end
    // The fall is recorded on the next edge; a clear on that same edge must lose.
    irq_clr = 8'h04;
    exp_q.push_back(8'h04);
    step(1);
    irq_clr = 8'h00;
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL set_wins got=%h exp=%h", irq_status, e); end
    irq_clr = 8'h04;
    exp_q.push_back(8'h00);
    step(1);
    irq_clr = 8'h00;
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL set_wins_clr got=%h exp=%h", irq_status, e); end
  endtask

  task automatic test_inactive();
    rise_en = 8'hFF; fall_en = 8'hFF;
    config_done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    end
    for (int k = 0; k < 24; k++) begin
      soc_in[3] = (k < 8) ? 1'b1 : ((k < 16) ? 1'b0 : 1'b1);
      step(1);
      e = exp_q.pop_front(); vectors++;
      if (fpga_in !== e) begin miscompares++; $display("FAIL inact_fpga_in step=%0d got=%h exp=%h", k, fpga_in, e); end
      e = exp_q.pop_front(); vectors++;
      if (irq_status !== e) begin miscompares++; $display("FAIL inact_status step=%0d got=%h exp=%h", k, irq_status, e); end
    end
    config_done = 1'b1;
    exp_q.push_back(soc_in);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (fpga_in !== e) begin miscompares++; $display("FAIL react_fpga_in got=%h exp=%h", fpga_in, e); end
    exp_q.push_back(8'h00);
    step(1);
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL react_status got=%h exp=%h", irq_status, e); end
  endtask

  task automatic test_reset_mid_debounce();
    soc_in[4] = 1'b1;
    step(4);
    reset = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    step(1);
    reset = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (soc_out !== e) begin miscompares++; $display("FAIL mid_rst_soc_out got=%h exp=%h", soc_out, e); end
    e = exp_q.pop_front(); vectors++;
    if (soc_dir !== e) begin miscompares++; $display("FAIL mid_rst_soc_dir got=%h exp=%h", soc_dir, e); end
    e = exp_q.pop_front(); vectors++;
    if (fpga_in !== e) begin miscompares++; $display("FAIL mid_rst_fpga_in got=%h exp=%h", fpga_in, e); end
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL mid_rst_status got=%h exp=%h", irq_status, e); end
    e = exp_q.pop_front(); vectors++;
    if ({7'd0, irq} !== e) begin miscompares++; $display("FAIL mid_rst_irq got=%b exp=%b", irq, e[0]); end
    // Every high channel must re-debounce from scratch: 2 sync edges plus 4 debounce edges.
    for (int k = 1; k <= 6; k++) exp_q.push_back((k == 6) ? soc_in : 8'h00);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k == 1) begin
        vectors++;
        if (soc_out !== 8'hA5) begin miscompares++; $display("FAIL post_rst_soc_out got=%h exp=%h", soc_out, 8'hA5); end
      end
      e = exp_q.pop_front(); vectors++;
      if (fpga_in !== e) begin miscompares++; $display("FAIL post_rst_db edge=%0d got=%h exp=%h", k, fpga_in, e); end
    end
    exp_q.push_back(soc_in);
    step(1);
    e = exp_q.pop_front(); vectors++;
    if (irq_status !== e) begin miscompares++; $display("FAIL post_rst_status got=%h exp=%h", irq_status, e); end
  endtask

  initial begin
    test_reset();
    test_output_path();
    test_debounce();
    test_irq_rise_clear();
    test_set_wins();
    test_inactive();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
